// File: rtl/stark_fpu_issue_station_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stark_fpu_issue_station_pkg
// Description : Shared types, sizes and the operand-capture helper for the
//               FPU issue station and its age selector.
// Revision    : 1.0 - initial release
// ============================================================================
package stark_fpu_issue_station_pkg;

    localparam int FPU_RS_NENT   = 4;
    localparam int FPU_WID       = 64;
    localparam int PREG_W        = 8;
    localparam int ROB_ENTRIES   = 16;
    localparam int ROB_NDX_W     = $clog2(ROB_ENTRIES);
    localparam int FPU_RS_AGE_W  = 4;
    localparam int FPU_RS_CNT_W  = 6;

    typedef logic [PREG_W-1:0]      pregno_t;
    typedef logic [ROB_NDX_W-1:0]   rob_ndx_t;
    typedef logic [ROB_ENTRIES-1:0] rob_bitmask_t;

    // Entry handed to the FPU; the four argument fields carry operand values.
    typedef struct packed {
        logic [7:0]         op;
        logic [2:0]         rm;
        rob_ndx_t           rndx;
        pregno_t            pRt;
        logic [FPU_WID-1:0] argA;
        logic [FPU_WID-1:0] argB;
        logic [FPU_WID-1:0] argC;
        logic [FPU_WID-1:0] argD;
    } reservation_station_entry_t;

    // Station slot: entry plus per-operand valid bit and source tag.
    typedef struct packed {
        reservation_station_entry_t rse;
        logic    aV;
        logic    bV;
        logic    cV;
        logic    dV;
        pregno_t pRa;
        pregno_t pRb;
        pregno_t pRc;
        pregno_t pRd;
    } fpu_rs_slot_t;

    typedef enum logic [0:0] {
        FRS_IDLE = 1'b0,
        FRS_WAIT = 1'b1
    } fpu_rs_state_e;

    // Fill every still-missing operand whose tag matches the bypass bus.
    function automatic fpu_rs_slot_t fpu_rs_capture(
        input fpu_rs_slot_t       s,
        input logic               v,
        input pregno_t            tag,
        input logic [FPU_WID-1:0] data
    );
        fpu_rs_slot_t r;
        r = s;
        if (v) begin
            if (!s.aV && (s.pRa == tag)) begin
                r.rse.argA = data;
                r.aV       = 1'b1;
            end
            if (!s.bV && (s.pRb == tag)) begin
                r.rse.argB = data;
                r.bV       = 1'b1;
            end
            if (!s.cV && (s.pRc == tag)) begin
                r.rse.argC = data;
                r.cV       = 1'b1;
            end
            if (!s.dV && (s.pRd == tag)) begin
                r.rse.argD = data;
                r.dV       = 1'b1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stark_fpu_issue_station_age_select.sv
`default_nettype none
// ============================================================================
// Module      : stark_fpu_rs_age_select
// Description : Combinational oldest-ready picker. Returns a one-hot select of
//               the ready slot with the largest age; ties favour lower index.
// Revision    : 1.0 - initial release
// ============================================================================
module stark_fpu_rs_age_select
    import stark_fpu_issue_station_pkg::*;
#(
    parameter int NENT = FPU_RS_NENT
)(
    input  logic [NENT-1:0]                   ready,
    input  logic [NENT-1:0][FPU_RS_AGE_W-1:0] age,
    output logic [NENT-1:0]                   sel,
    output logic                              any_ready
);

    logic [FPU_RS_AGE_W-1:0] w_best_age;

    // Upward scan; strict greater-than keeps the lower index on equal ages.
    always_comb begin
        sel        = '0;
        any_ready  = 1'b0;
        w_best_age = '0;
        for (int i = 0; i < NENT; i++) begin
            if (ready[i] && (!any_ready || (age[i] > w_best_age))) begin
                sel        = '0;
                sel[i]     = 1'b1;
                any_ready  = 1'b1;
                w_best_age = age[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stark_fpu_issue_station.sv
`default_nettype none
// ============================================================================
// Module      : stark_fpu_issue_station
// Description : FPU reservation station. Buffers dispatched ops, captures late
//               operands from the bypass bus, issues the oldest ready op and
//               then waits for the FPU to report done (with a timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module stark_fpu_issue_station
    import stark_fpu_issue_station_pkg::*;
#(
    parameter int NENT   = FPU_RS_NENT,
    parameter int WID    = FPU_WID,
    parameter int MAXLAT = 63
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       disp_v,
    input  fpu_rs_slot_t               disp_slot,
    output logic                       disp_rdy,
    input  logic                       byp_v,
    input  pregno_t                    byp_tag,
    input  logic [WID-1:0]             byp_data,
    input  rob_bitmask_t               stomp,
    input  logic                       fpu_idle,
    input  logic                       fpu_done,
    output logic                       fpu_v,
    output reservation_station_entry_t fpu_rse,
    output logic                       busy,
    output logic                       tmo
);

    // Counter value at which the next WAIT cycle reaches MAXLAT.
    localparam logic [FPU_RS_CNT_W-1:0] c_LAST = FPU_RS_CNT_W'(MAXLAT - 1);

    // Slot storage and bookkeeping
    fpu_rs_slot_t [NENT-1:0]                  r_slot;
    logic         [NENT-1:0]                  r_valid;
    logic         [NENT-1:0][FPU_RS_AGE_W-1:0] r_age;
    logic                                     r_disp_rdy;

    // Issue FSM state and registered outputs
    fpu_rs_state_e                 r_state;
    logic [FPU_RS_CNT_W-1:0]       r_cnt;
    logic                          r_fpu_v;
    reservation_station_entry_t    r_fpu_rse;
    logic                          r_busy;
    logic                          r_tmo;

    logic [FPU_WID-1:0]            w_byp_data;
    fpu_rs_slot_t                  w_disp_cap;
    logic                          w_disp_fire;
    logic [NENT-1:0]               w_free_oh;
    logic                          w_free_found;
    logic [NENT-1:0]               w_ready;
    logic [NENT-1:0]               w_sel;
    logic                          w_any_ready;
    logic                          w_issue;
    reservation_station_entry_t    w_sel_rse;
    logic [NENT-1:0]               w_valid_nxt;

    assign w_byp_data  = FPU_WID'(byp_data);
    assign w_disp_fire = disp_v & r_disp_rdy;
    assign w_disp_cap  = fpu_rs_capture(disp_slot, byp_v, byp_tag, w_byp_data);
    assign w_issue     = (r_state == FRS_IDLE) & w_any_ready & fpu_idle;

    // Lowest-index free slot receives the next dispatch.
    always_comb begin
        w_free_oh    = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_oh[i] = 1'b1;
                w_free_found = 1'b1;
            end
        end
    end

    // A slot is ready with all four operands present and its ROB entry not stomped.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NENT; i++) begin
            w_ready[i] = r_valid[i] & r_slot[i].aV & r_slot[i].bV & r_slot[i].cV
                       & r_slot[i].dV & ~stomp[r_slot[i].rse.rndx];
        end
    end

    stark_fpu_rs_age_select #(
        .NENT (NENT)
    ) u_age_select (
        .ready     (w_ready),
        .age       (r_age),
        .sel       (w_sel),
        .any_ready (w_any_ready)
    );

    // One-hot mux of the selected slot's entry.
    always_comb begin
        w_sel_rse = '0;
        for (int i = 0; i < NENT; i++) begin
            if (w_sel[i]) begin
                w_sel_rse = r_slot[i].rse;
            end
        end
    end

    // Next occupancy: dispatch fills (invalid if stomped), issue and stomp free.
    always_comb begin
        w_valid_nxt = r_valid;
        for (int i = 0; i < NENT; i++) begin
            if (w_disp_fire && w_free_oh[i]) begin
                w_valid_nxt[i] = ~stomp[disp_slot.rse.rndx];
            end else if ((w_issue && w_sel[i]) || stomp[r_slot[i].rse.rndx]) begin
                w_valid_nxt[i] = 1'b0;
            end
        end
    end

    // Slot contents, ages and occupancy; disp_rdy is registered from occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot     <= '0;
            r_valid    <= '0;
            r_age      <= '0;
            r_disp_rdy <= 1'b1;
        end else begin
            r_valid    <= w_valid_nxt;
            r_disp_rdy <= ~(&w_valid_nxt);
            for (int i = 0; i < NENT; i++) begin
                if (w_disp_fire && w_free_oh[i]) begin
                    r_slot[i] <= w_disp_cap;
                    r_age[i]  <= '0;
                end else if (r_valid[i]) begin
                    r_slot[i] <= fpu_rs_capture(r_slot[i], byp_v, byp_tag, w_byp_data);
                    if (r_age[i] != '1) begin
                        r_age[i] <= r_age[i] + FPU_RS_AGE_W'(1);
                    end
                end
            end
        end
    end

    // Issue FSM: launch one op from IDLE, then hold until done or timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= FRS_IDLE;
            r_cnt     <= '0;
            r_fpu_v   <= 1'b0;
            r_fpu_rse <= '0;
            r_busy    <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_fpu_v <= 1'b0;
            case (r_state)
                FRS_IDLE: begin
                    if (w_issue) begin
                        r_fpu_v   <= 1'b1;
                        r_fpu_rse <= w_sel_rse;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= FRS_WAIT;
                    end
                end
                FRS_WAIT: begin
                    r_cnt <= r_cnt + FPU_RS_CNT_W'(1);
                    if (fpu_done) begin
                        r_busy  <= 1'b0;
                        r_state <= FRS_IDLE;
                    end else if (r_cnt == c_LAST) begin
                        r_tmo   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FRS_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= FRS_IDLE;
                end
            endcase
        end
    end

    assign disp_rdy = r_disp_rdy;
    assign fpu_v    = r_fpu_v;
    assign fpu_rse  = r_fpu_rse;
    assign busy     = r_busy;
    assign tmo      = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_stark_fpu_issue_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_stark_fpu_issue_station
// Description : Directed self-checking bench with an expected-issue queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stark_fpu_issue_station;
    import stark_fpu_issue_station_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       disp_v;
    fpu_rs_slot_t               disp_slot;
    logic                       disp_rdy;
    logic                       byp_v;
    pregno_t                    byp_tag;
    logic [63:0]                byp_data;
    rob_bitmask_t               stomp;
    logic                       fpu_idle;
    logic                       fpu_done;
    logic                       fpu_v;
    reservation_station_entry_t fpu_rse;
    logic                       busy;
    logic                       tmo;

    int n_checks = 0;
    int n_fail   = 0;
    int n_issued = 0;
    reservation_station_entry_t exp_q[$];

    stark_fpu_issue_station dut (
        .clk       (clk),
        .rst       (rst),
        .disp_v    (disp_v),
        .disp_slot (disp_slot),
        .disp_rdy  (disp_rdy),
        .byp_v     (byp_v),
        .byp_tag   (byp_tag),
        .byp_data  (byp_data),
        .stomp     (stomp),
        .fpu_idle  (fpu_idle),
        .fpu_done  (fpu_done),
        .fpu_v     (fpu_v),
        .fpu_rse   (fpu_rse),
        .busy      (busy),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_rse(input string tag, input reservation_station_entry_t obs,
                             input reservation_station_entry_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and score any issue seen against the queue head.
    task automatic step();
        reservation_station_entry_t e;
        @(negedge clk);
        if (fpu_v === 1'b1) begin
            n_issued++;
            check_bit("issue_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_rse("issue_rse", fpu_rse, e);
            end
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic dispatch(input fpu_rs_slot_t s);
        disp_v    = 1'b1;
        disp_slot = s;
        step();
        disp_v    = 1'b0;
    endtask

    task automatic done();
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
    endtask

    task automatic bypass(input pregno_t tag, input logic [63:0] data);
        byp_v    = 1'b1;
        byp_tag  = tag;
        byp_data = data;
        step();
        byp_v    = 1'b0;
    endtask

    task automatic stomp_one(input int idx);
        stomp      = '0;
        stomp[idx] = 1'b1;
        step();
        stomp      = '0;
    endtask

    task automatic wait_issue(input string tag, input int budget);
        int start;
        int k;
        start = n_issued;
        k     = 0;
        while ((n_issued == start) && (k < budget)) begin
            step();
            k++;
        end
        check_bit(tag, n_issued != start, 1'b1);
    endtask

    // v = {aV,bV,cV,dV}; all four source tags are set to tag.
    function automatic fpu_rs_slot_t mk(input logic [7:0] op, input rob_ndx_t rndx,
                                        input logic [3:0] v, input pregno_t tag);
        fpu_rs_slot_t s;
        s          = '0;
        s.rse.op   = op;
        s.rse.rm   = 3'd3;
        s.rse.rndx = rndx;
        s.rse.pRt  = op ^ 8'h80;
        s.rse.argA = {8'hA0, op, 48'h1111_2222_3333};
        s.rse.argB = {8'hB0, op, 48'h4444_5555_6666};
        s.rse.argC = {8'hC0, op, 48'h7777_8888_9999};
        s.rse.argD = {8'hD0, op, 48'hAAAA_BBBB_CCCC};
        s.aV = v[3];
        s.bV = v[2];
        s.cV = v[1];
        s.dV = v[0];
        s.pRa = tag;
        s.pRb = tag;
        s.pRc = tag;
        s.pRd = tag;
        return s;
    endfunction

    // Expected issued entry: missing operands take the bypass value.
    function automatic reservation_station_entry_t exp_of(input fpu_rs_slot_t s,
                                                          input logic [63:0] d);
        reservation_station_entry_t e;
        e = s.rse;
        if (!s.aV) e.argA = d;
        if (!s.bV) e.argB = d;
        if (!s.cV) e.argC = d;
        if (!s.dV) e.argD = d;
        return e;
    endfunction

    fpu_rs_slot_t s1, s2, blk, x, y, w0, w1, p0, p1, r2, q3, q4, t6, m0;
    fpu_rs_slot_t d[5];
    int           base;

    initial begin
        rst = 1'b0; disp_v = 1'b0; disp_slot = '0; byp_v = 1'b0; byp_tag = '0;
        byp_data = '0; stomp = '0; fpu_idle = 1'b1; fpu_done = 1'b0;
        idle_steps(2);
        check_bit("rst_fpu_v", fpu_v, 1'b0);
        check_rse("rst_fpu_rse", fpu_rse, '0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_tmo", tmo, 1'b0);
        check_bit("rst_disp_rdy", disp_rdy, 1'b1);
        rst = 1'b1;
        step();

        // All operands valid: issue follows dispatch, busy until done.
        s1 = mk(8'h11, 4'd1, 4'b1111, 8'h00);
        exp_q.push_back(s1.rse);
        dispatch(s1);
        wait_issue("t1_issue", 1);
        check_bit("t1_busy", busy, 1'b1);
        idle_steps(3);
        check_bit("t1_busy_hold", busy, 1'b1);
        done();
        check_bit("t1_busy_clear", busy, 1'b0);

        // Late operand B arrives over the bypass bus three cycles later.
        s2 = mk(8'h22, 4'd2, 4'b1011, 8'h21);
        exp_q.push_back(exp_of(s2, 64'h4000_0000_0000_0000));
        base = n_issued;
        dispatch(s2);
        idle_steps(3);
        check_bit("t2_no_early", n_issued == base, 1'b1);
        bypass(8'h21, 64'h4000_0000_0000_0000);
        check_bit("t2_not_same_cycle", n_issued == base, 1'b1);
        wait_issue("t2_issue", 1);
        done();

        // Fill all slots, drop a fifth dispatch, then drain in age order.
        fpu_idle = 1'b0;
        for (int i = 0; i < 5; i++) d[i] = mk(8'h30 + 8'(i), rob_ndx_t'(4 + i), 4'b1111, 8'h00);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(d[i].rse);
            dispatch(d[i]);
        end
        check_bit("t3_full", disp_rdy, 1'b0);
        dispatch(d[4]);
        check_bit("t3_still_full", disp_rdy, 1'b0);
        fpu_idle = 1'b1;
        wait_issue("t3_issue0", 1);
        check_bit("t3_rdy_after_issue", disp_rdy, 1'b1);
        for (int i = 1; i < 4; i++) begin
            done();
            wait_issue("t3_issue_n", 2);
        end
        done();
        idle_steps(3);
        check_bit("t3_drained", exp_q.size() == 0, 1'b1);

        // Older op in slot 1 (age 5) beats younger op in slot 0 (age 2).
        fpu_idle = 1'b0;
        blk = mk(8'h40, 4'd10, 4'b0111, 8'h55);
        x   = mk(8'h41, 4'd11, 4'b1111, 8'h00);
        y   = mk(8'h42, 4'd12, 4'b1111, 8'h00);
        dispatch(blk);
        dispatch(x);
        stomp_one(10);
        step();
        dispatch(y);
        idle_steps(2);
        exp_q.push_back(x.rse);
        exp_q.push_back(y.rse);
        fpu_idle = 1'b1;
        wait_issue("t4_age_first", 1);
        done();
        wait_issue("t4_age_second", 2);
        done();

        // Both saturated at 15: tie goes to slot 0 even though slot 1 is older.
        fpu_idle = 1'b0;
        blk = mk(8'h43, 4'd13, 4'b0111, 8'h55);
        w1  = mk(8'h44, 4'd14, 4'b1111, 8'h00);
        w0  = mk(8'h45, 4'd15, 4'b1111, 8'h00);
        dispatch(blk);
        dispatch(w1);
        stomp_one(13);
        dispatch(w0);
        idle_steps(16);
        exp_q.push_back(w0.rse);
        exp_q.push_back(w1.rse);
        fpu_idle = 1'b1;
        wait_issue("t4_tie_first", 1);
        done();
        wait_issue("t4_tie_second", 2);
        done();

        // Stomp slot 2 in the very cycle it is selectable; it must not issue.
        p0 = mk(8'h50, 4'd0, 4'b0111, 8'h40);
        p1 = mk(8'h51, 4'd3, 4'b0111, 8'h40);
        r2 = mk(8'h52, 4'd9, 4'b1111, 8'h00);
        base = n_issued;
        dispatch(p0);
        dispatch(p1);
        dispatch(r2);
        stomp_one(9);
        check_bit("t5_stomp_no_issue", n_issued == base, 1'b1);
        step();
        check_bit("t5_stomp_gone", n_issued == base, 1'b1);
        fpu_idle = 1'b0;
        q3 = mk(8'h53, 4'd5, 4'b1111, 8'h00);
        q4 = mk(8'h54, 4'd6, 4'b1111, 8'h00);
        dispatch(q3);
        check_bit("t5_slot2_freed", disp_rdy, 1'b1);
        dispatch(q4);
        check_bit("t5_full_again", disp_rdy, 1'b0);
        exp_q.push_back(exp_of(p0, 64'hC0FF_EE00_1234_5678));
        exp_q.push_back(exp_of(p1, 64'hC0FF_EE00_1234_5678));
        exp_q.push_back(q3.rse);
        exp_q.push_back(q4.rse);
        bypass(8'h40, 64'hC0FF_EE00_1234_5678);
        fpu_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_issue("t5_drain", 2);
            done();
        end

        // No done: stomp mid-WAIT is ignored, timeout after 63 wait cycles.
        t6 = mk(8'h60, 4'd7, 4'b1111, 8'h00);
        exp_q.push_back(t6.rse);
        dispatch(t6);
        wait_issue("t6_issue", 1);
        stomp_one(7);
        idle_steps(61);
        check_bit("t6_busy_before_tmo", busy, 1'b1);
        check_bit("t6_tmo_before", tmo, 1'b0);
        step();
        check_bit("t6_tmo_set", tmo, 1'b1);
        check_bit("t6_busy_after_tmo", busy, 1'b0);

        // Asynchronous reset in the middle of WAIT with a full station.
        fpu_idle = 1'b0;
        m0 = mk(8'h70, 4'd1, 4'b1111, 8'h00);
        exp_q.push_back(m0.rse);
        dispatch(m0);
        for (int i = 0; i < 3; i++) dispatch(mk(8'h71 + 8'(i), rob_ndx_t'(2 + i), 4'b0111, 8'h77));
        fpu_idle = 1'b1;
        wait_issue("t7_issue", 1);
        dispatch(mk(8'h78, 4'd8, 4'b0111, 8'h77));
        check_bit("t7_full", disp_rdy, 1'b0);
        check_bit("t7_busy", busy, 1'b1);
        check_bit("t7_tmo_sticky", tmo, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        check_bit("t7_rst_fpu_v", fpu_v, 1'b0);
        check_rse("t7_rst_fpu_rse", fpu_rse, '0);
        check_bit("t7_rst_busy", busy, 1'b0);
        check_bit("t7_rst_tmo", tmo, 1'b0);
        check_bit("t7_rst_disp_rdy", disp_rdy, 1'b1);
        idle_steps(2);
        rst = 1'b1;
        base = n_issued;
        bypass(8'h77, 64'h0123_4567_89AB_CDEF);
        idle_steps(4);
        check_bit("t7_slots_cleared", n_issued == base, 1'b1);
        check_bit("final_queue_empty", exp_q.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
